multicycle_cu: RTL and testbench

Multi-cycle MIPS32 control unit: an FSM that sequences fetch/decode/execute/memory/writeback over several clocks instead of decoding in one cycle.
Sits between the instruction register and the shared-ALU/single-memory datapath of the multi-cycle core.
Adds a memory wait handshake, a resumable halt and an optional iterative multiply/divide stall.

---
 rtl/multicycle_cu_pkg.sv | 74 +++++++
 rtl/multicycle_cu_inst_decode.sv | 49 ++++
 rtl/multicycle_cu.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_cu_pkg.sv
// Shared definitions for the multi-cycle MIPS32 control unit:
// opcode/func constants, ALU operation codes, FSM state encodings,
// mux select codes and the decoded-instruction flag bundle.
package multicycle_cu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_OR      = 6'h25;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_MULU = 4'd3;
  localparam logic [3:0] ALU_DIVU = 4'd4;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] REGDES_RT  = 2'd0;
  localparam logic [1:0] REGDES_RD  = 2'd1;
  localparam logic [1:0] REGDES_R31 = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_MD     = 3'd6
  } state_t;

  // One flag per supported instruction; r_alu covers both add and or.
  typedef struct packed {
    logic j;
    logic jal;
    logic jr;
    logic syscall;
    logic r_alu;
    logic r_or;
    logic addi;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic multu;
    logic divu;
    logic legal;
  } inst_t;

endpackage

// File: rtl/multicycle_cu_inst_decode.sv
// Combinational op/func to instruction-flag decode.
// MULDIV_EN: when defined, multu/divu are recognised; otherwise they
// decode as illegal.
module multicycle_cu_inst_decode
  import multicycle_cu_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int FUNC_W = 6
) (
  input  logic [OP_W-1:0]   op,
  input  logic [FUNC_W-1:0] func,
  output inst_t             dec
);

  // Flag the matching instruction, then derive legality from the flags.
  always_comb begin
    dec = '0;
    if (op == OP_W'(OP_RTYPE)) begin
      case (func)
        FUNC_W'(FN_ADD):     dec.r_alu = 1'b1;
        FUNC_W'(FN_OR):      begin dec.r_alu = 1'b1; dec.r_or = 1'b1; end
        FUNC_W'(FN_JR):      dec.jr = 1'b1;
        FUNC_W'(FN_SYSCALL): dec.syscall = 1'b1;
`ifdef MULDIV_EN
        FUNC_W'(FN_MULTU):   dec.multu = 1'b1;
        FUNC_W'(FN_DIVU):    dec.divu = 1'b1;
`endif
        default: ;
      endcase
    end else begin
      case (op)
        OP_W'(OP_J):    dec.j = 1'b1;
        OP_W'(OP_JAL):  dec.jal = 1'b1;
        OP_W'(OP_BEQ):  dec.beq = 1'b1;
        OP_W'(OP_BNE):  dec.bne = 1'b1;
        OP_W'(OP_ADDI): dec.addi = 1'b1;
        OP_W'(OP_ORI):  dec.ori = 1'b1;
        OP_W'(OP_LUI):  dec.lui = 1'b1;
        OP_W'(OP_LW):   dec.lw = 1'b1;
        OP_W'(OP_SW):   dec.sw = 1'b1;
        default: ;
      endcase
    end
    dec.legal = dec.j | dec.jal | dec.jr | dec.syscall | dec.r_alu |
                dec.addi | dec.ori | dec.lui | dec.lw | dec.sw |
                dec.beq | dec.bne | dec.multu | dec.divu;
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS32 control unit: sequences fetch/decode/execute/
// memory/writeback with a memory wait handshake and a resumable halt.
// MULDIV_EN: when defined, multu/divu stall in MD for MD_CYCLES clocks.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR and PC+4 on mem_ready
// DECODE | compute branch target; finish jumps, halt on syscall
// EXEC   | ALU operation, address calc or branch compare
// MEM    | data read/write, held until mem_ready
// WB     | single register-file write
// HALT   | stopped until a go pulse
// MD     | iterative multiply/divide stall
module multicycle_cu
  import multicycle_cu_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int FUNC_W    = 6,
  parameter int ALUOP_W   = 4,
  parameter int MD_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNC_W-1:0]  func,
  input  logic               Z,
  input  logic               mem_ready,
  input  logic               go,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               nWriteMEM,
  output logic               MEMtoREG,
  output logic               nWriteREG,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic [1:0]         PCSource,
  output logic [1:0]         REGDes,
  output logic               Sigextend,
  output logic               Lui,
  output logic               Halt,
  output logic               Illegal,
  output logic [2:0]         state_o
);

  state_t     state_q, state_d;
  inst_t      dec;
  logic [3:0] alu_op;

`ifdef MULDIV_EN
  localparam int MD_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  logic [MD_W-1:0] md_cnt_q, md_cnt_d;
`endif

  multicycle_cu_inst_decode #(.OP_W(OP_W), .FUNC_W(FUNC_W)) u_dec (
    .op   (op),
    .func (func),
    .dec  (dec)
  );

  // Next-state selection and MD countdown.
  always_comb begin
    state_d = state_q;
`ifdef MULDIV_EN
    md_cnt_d = md_cnt_q;
`endif
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (dec.syscall)                                 state_d = S_HALT;
        else if (dec.j | dec.jal | dec.jr | ~dec.legal)  state_d = S_FETCH;
        else                                             state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec.lw | dec.sw)                              state_d = S_MEM;
        else if (dec.r_alu | dec.addi | dec.ori | dec.lui) state_d = S_WB;
`ifdef MULDIV_EN
        else if (dec.multu | dec.divu) begin
          state_d  = S_MD;
          md_cnt_d = MD_W'(MD_CYCLES - 1);
        end
`endif
        else                                              state_d = S_FETCH;
      end
      S_MEM:    if (mem_ready) state_d = dec.lw ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   if (go) state_d = S_FETCH;
`ifdef MULDIV_EN
      S_MD: begin
        if (md_cnt_q == '0) state_d = S_FETCH;
        else                md_cnt_d = md_cnt_q - 1'b1;
      end
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // State register, cleared asynchronously to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
`ifdef MULDIV_EN
      md_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MULDIV_EN
      md_cnt_q <= md_cnt_d;
`endif
    end
  end

  // Datapath controls from state, instruction flags, Z and mem_ready.
  // Strobes are forced inactive while rst_n is low, since FETCH with
  // mem_ready high would otherwise load PC/IR during reset.
  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    nWriteMEM = 1'b1;
    MEMtoREG  = 1'b0;
    nWriteREG = 1'b1;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RT;
    alu_op    = ALU_ADD;
    PCSource  = PCSRC_ALU;
    REGDes    = REGDES_RT;
    Sigextend = 1'b0;
    Lui       = 1'b0;
    Halt      = 1'b0;
    Illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB   = SRCB_IMM_SH2;
        Sigextend = 1'b1;
        if (dec.j | dec.jal) begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        if (dec.jal) begin
          nWriteREG = 1'b0;
          REGDes    = REGDES_R31;
        end
        if (dec.jr) begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_RS;
        end
        Illegal = ~dec.legal;
      end
      S_EXEC: begin
        if (dec.r_alu) begin
          ALUSrcA = 1'b1;
          alu_op  = dec.r_or ? ALU_OR : ALU_ADD;
        end
        if (dec.addi | dec.lw | dec.sw) begin
          ALUSrcB   = SRCB_IMM;
          Sigextend = 1'b1;
        end
        if (dec.ori) begin
          ALUSrcB = SRCB_IMM;
          alu_op  = ALU_OR;
        end
        if (dec.lui) begin
          ALUSrcB = SRCB_IMM;
          Lui     = 1'b1;
        end
        if (dec.beq | dec.bne) begin
          ALUSrcA = 1'b1;
          alu_op  = ALU_SUB;
          if ((dec.beq & Z) | (dec.bne & ~Z)) begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_ALUOUT;
          end
        end
`ifdef MULDIV_EN
        if (dec.multu | dec.divu) begin
          ALUSrcA = 1'b1;
          alu_op  = dec.divu ? ALU_DIVU : ALU_MULU;
        end
`endif
      end
      S_MEM: begin
        IorD      = 1'b1;
        MemRead   = dec.lw;
        nWriteMEM = ~dec.sw;
      end
      S_WB: begin
        nWriteREG = 1'b0;
        REGDes    = dec.r_alu ? REGDES_RD : REGDES_RT;
        MEMtoREG  = dec.lw;
      end
      S_HALT:   Halt = 1'b1;
`ifdef MULDIV_EN
      S_MD: begin
        ALUSrcA = 1'b1;
        alu_op  = dec.divu ? ALU_DIVU : ALU_MULU;
      end
`endif
      default: ;
    endcase
    if (!rst_n) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemRead   = 1'b0;
      nWriteMEM = 1'b1;
      nWriteREG = 1'b1;
      Illegal   = 1'b0;
    end
  end

  assign ALUOP   = ALUOP_W'(alu_op);
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Self-checking bench for multicycle_cu: directed scenarios followed by
// a randomized instruction stream, checked cycle by cycle against a
// per-instruction phase model. Honors MULDIV_EN like the design.
module tb_multicycle_cu;
  import multicycle_cu_pkg::*;

  localparam int MD_CYC = 4;
`ifdef MULDIV_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXEC = 2, ST_MEM = 3,
                 ST_WB = 4, ST_HALT = 5, ST_MD = 6;

  typedef enum int {C_RADD, C_ROR, C_ADDI, C_ORI, C_LUI, C_LW, C_SW, C_BEQ,
                    C_BNE, C_J, C_JAL, C_JR, C_SYSCALL, C_MULTU, C_DIVU,
                    C_BAD, C_NUM} cls_t;

  typedef struct { int st; bit last; } step_t;

  logic clk = 1'b0;
  logic rst_n, Z, mem_ready, go;
  logic [5:0] op, func;
  logic PCWrite, IRWrite, IorD, MemRead, nWriteMEM, MEMtoREG, nWriteREG;
  logic ALUSrcA, Sigextend, Lui, Halt, Illegal;
  logic [1:0] ALUSrcB, PCSource, REGDes;
  logic [3:0] ALUOP;
  logic [2:0] state_o;

  int vectors = 0, fails = 0;
  step_t seq[$];

  always #5 clk = ~clk;

  multicycle_cu #(.OP_W(6), .FUNC_W(6), .ALUOP_W(4), .MD_CYCLES(MD_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .Z(Z),
    .mem_ready(mem_ready), .go(go), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .IorD(IorD), .MemRead(MemRead), .nWriteMEM(nWriteMEM),
    .MEMtoREG(MEMtoREG), .nWriteREG(nWriteREG), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOP(ALUOP), .PCSource(PCSource), .REGDes(REGDes),
    .Sigextend(Sigextend), .Lui(Lui), .Halt(Halt), .Illegal(Illegal),
    .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enc(input cls_t c, output logic [5:0] o, output logic [5:0] f);
    o = 6'h00;
    f = 6'h00;
    case (c)
      C_RADD:    f = 6'h20;
      C_ROR:     f = 6'h25;
      C_JR:      f = 6'h08;
      C_SYSCALL: f = 6'h0C;
      C_MULTU:   f = 6'h19;
      C_DIVU:    f = 6'h1B;
      C_ADDI:    o = 6'h08;
      C_ORI:     o = 6'h0D;
      C_LUI:     o = 6'h0F;
      C_LW:      o = 6'h23;
      C_SW:      o = 6'h2B;
      C_BEQ:     o = 6'h04;
      C_BNE:     o = 6'h05;
      C_J:       o = 6'h02;
      C_JAL:     o = 6'h03;
      default: begin
        if ($urandom_range(0, 1) == 1) o = 6'h3F;
        else f = 6'h3F;
      end
    endcase
    if (c != C_BAD && o == 6'h00 && f == 6'h00) f = 6'h3F;
  endtask

  function automatic bit is_bad(input cls_t c);
    return (c == C_BAD) || (!MD_ON && (c == C_MULTU || c == C_DIVU));
  endfunction

  // Phase list of one instruction: FETCH waits fw, MEM waits / HALT holds mw.
  function automatic void build(input cls_t c, input int fw, input int mw);
    seq.delete();
    for (int i = 0; i <= fw; i++) seq.push_back('{st: ST_FETCH, last: (i == fw)});
    seq.push_back('{st: ST_DECODE, last: 1'b1});
    if (is_bad(c)) return;
    case (c)
      C_SYSCALL: for (int i = 0; i <= mw; i++) seq.push_back('{st: ST_HALT, last: (i == mw)});
      C_RADD, C_ROR, C_ADDI, C_ORI, C_LUI: begin
        seq.push_back('{st: ST_EXEC, last: 1'b1});
        seq.push_back('{st: ST_WB, last: 1'b1});
      end
      C_LW, C_SW: begin
        seq.push_back('{st: ST_EXEC, last: 1'b1});
        for (int i = 0; i <= mw; i++) seq.push_back('{st: ST_MEM, last: (i == mw)});
        if (c == C_LW) seq.push_back('{st: ST_WB, last: 1'b1});
      end
      C_BEQ, C_BNE: seq.push_back('{st: ST_EXEC, last: 1'b1});
      C_MULTU, C_DIVU: begin
        seq.push_back('{st: ST_EXEC, last: 1'b1});
        for (int i = 0; i < MD_CYC; i++) seq.push_back('{st: ST_MD, last: (i == MD_CYC - 1)});
      end
      default: ;
    endcase
  endfunction

  // Clocks per instruction with zero wait, from the latency table.
  function automatic int exp_len(input cls_t c, input int fw, input int mw);
    int base;
    if (is_bad(c)) return 2 + fw;
    case (c)
      C_J, C_JAL, C_JR: base = 2;
      C_BEQ, C_BNE:     base = 3;
      C_LW:             base = 5 + mw;
      C_SW:             base = 4 + mw;
      C_SYSCALL:        base = 3 + mw;
      C_MULTU, C_DIVU:  base = 3 + MD_CYC;
      default:          base = 4;
    endcase
    return base + fw;
  endfunction

  task automatic check_step(input string tag, input cls_t c, input int st,
                            input bit last, input bit z);
    bit e_pcw = 0, e_irw = 0, e_rd = 0, e_nwm = 1, e_nwr = 1, e_ill = 0, e_halt = 0;
    logic [1:0] e_pcsrc = 2'd0, e_regdes = 2'd0;
    chk({tag, ".state"}, state_o, st);
    case (st)
      ST_FETCH: begin
        e_rd = 1; e_irw = last; e_pcw = last;
        chk({tag, ".IorD"}, IorD, 0);
        chk({tag, ".ALUSrcB"}, ALUSrcB, 1);
      end
      ST_DECODE: begin
        chk({tag, ".ALUSrcB"}, ALUSrcB, 3);
        chk({tag, ".Sigextend"}, Sigextend, 1);
        if (c == C_J || c == C_JAL) begin e_pcw = 1; e_pcsrc = 2; end
        if (c == C_JR) begin e_pcw = 1; e_pcsrc = 3; end
        if (c == C_JAL) begin e_nwr = 0; e_regdes = 2; end
        e_ill = is_bad(c);
      end
      ST_EXEC: begin
        if ((c == C_BEQ && z) || (c == C_BNE && !z)) begin e_pcw = 1; e_pcsrc = 1; end
        if (c == C_BEQ || c == C_BNE) chk({tag, ".ALUOP"}, ALUOP, ALU_SUB);
        if (c == C_RADD || c == C_ROR) chk({tag, ".ALUSrcA"}, ALUSrcA, 1);
        if (c == C_ADDI || c == C_LW || c == C_SW) chk({tag, ".Sigextend"}, Sigextend, 1);
        if (c == C_ORI) chk({tag, ".Sigextend"}, Sigextend, 0);
        if (c == C_LUI) chk({tag, ".Lui"}, Lui, 1);
      end
      ST_MEM: begin
        chk({tag, ".IorD"}, IorD, 1);
        e_rd = (c == C_LW);
        e_nwm = (c != C_SW);
      end
      ST_WB: begin
        e_nwr = 0;
        e_regdes = (c == C_RADD || c == C_ROR) ? 2'd1 : 2'd0;
        chk({tag, ".MEMtoREG"}, MEMtoREG, c == C_LW);
      end
      ST_HALT: e_halt = 1;
      ST_MD: chk({tag, ".ALUOP"}, ALUOP, (c == C_DIVU) ? ALU_DIVU : ALU_MULU);
      default: ;
    endcase
    chk({tag, ".PCWrite"}, PCWrite, e_pcw);
    chk({tag, ".IRWrite"}, IRWrite, e_irw);
    chk({tag, ".MemRead"}, MemRead, e_rd);
    chk({tag, ".nWriteMEM"}, nWriteMEM, e_nwm);
    chk({tag, ".nWriteREG"}, nWriteREG, e_nwr);
    chk({tag, ".Illegal"}, Illegal, e_ill);
    chk({tag, ".Halt"}, Halt, e_halt);
    if (e_pcw) chk({tag, ".PCSource"}, PCSource, e_pcsrc);
    if (!e_nwr) chk({tag, ".REGDes"}, REGDes, e_regdes);
  endtask

  // Drive one instruction from FETCH back to FETCH, checking each cycle.
  task automatic run(input cls_t c, input int fw, input int mw, input bit z,
                     input string tag);
    logic [5:0] o, f;
    int n;
    enc(c, o, f);
    build(c, fw, mw);
    n = seq.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      op = o;
      func = f;
      if (seq[k].st == ST_FETCH || seq[k].st == ST_MEM) mem_ready = seq[k].last;
      else mem_ready = 1'($urandom_range(0, 1));
      if (seq[k].st == ST_HALT) go = seq[k].last;
      else go = 1'($urandom_range(0, 1));
      Z = (seq[k].st == ST_EXEC) ? z : 1'($urandom_range(0, 1));
      #1;
      check_step(tag, c, seq[k].st, seq[k].last, z);
    end
    @(posedge clk);
    #1;
    chk({tag, ".len"}, (state_o == 3'd0) ? n : -1, exp_len(c, fw, mw));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] o, f;
    rst_n = 1'b0; op = '0; func = '0; Z = 1'b0; mem_ready = 1'b1; go = 1'b1;
    #3;
    chk("rst.state", state_o, 0);
    chk("rst.PCWrite", PCWrite, 0);
    chk("rst.IRWrite", IRWrite, 0);
    chk("rst.MemRead", MemRead, 0);
    chk("rst.nWriteMEM", nWriteMEM, 1);
    chk("rst.nWriteREG", nWriteREG, 1);
    chk("rst.Halt", Halt, 0);
    chk("rst.Illegal", Illegal, 0);
    @(negedge clk);
    chk("rst_go.state", state_o, 0);
    rst_n = 1'b1; go = 1'b0; mem_ready = 1'b0;

    run(C_RADD, 0, 0, 0, "add");
    run(C_LW, 0, 3, 0, "lw_wait");
    run(C_BEQ, 0, 0, 1, "beq_z1");
    run(C_BEQ, 0, 0, 0, "beq_z0");
    run(C_BNE, 0, 0, 1, "bne_z1");
    run(C_BNE, 0, 0, 0, "bne_z0");
    run(C_JAL, 0, 0, 0, "jal");
    run(C_J, 2, 0, 0, "j_fwait");
    run(C_JR, 0, 0, 0, "jr");
    run(C_SYSCALL, 0, 10, 0, "syscall");
    run(C_MULTU, 0, 0, 0, "multu");
    run(C_DIVU, 1, 0, 0, "divu");
    run(C_BAD, 0, 0, 0, "illegal");

    // Reset in the middle of a waiting sw.
    enc(C_SW, o, f);
    op = o; func = f;
    @(negedge clk); mem_ready = 1'b1; go = 1'b0; #1;
    chk("swrst.fetch", state_o, 0);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("swrst.decode", state_o, 1);
    @(negedge clk); #1;
    chk("swrst.exec", state_o, 2);
    @(negedge clk); #1;
    chk("swrst.mem", state_o, 3);
    chk("swrst.mem_nWriteMEM", nWriteMEM, 0);
    #2;
    rst_n = 1'b0; go = 1'b1; mem_ready = 1'b1;
    #1;
    chk("swrst.abort_state", state_o, 0);
    chk("swrst.abort_nWriteMEM", nWriteMEM, 1);
    chk("swrst.abort_PCWrite", PCWrite, 0);
    chk("swrst.abort_IRWrite", IRWrite, 0);
    chk("swrst.abort_nWriteREG", nWriteREG, 1);
    @(negedge clk); #1;
    chk("swrst.held_state", state_o, 0);
    chk("swrst.held_PCWrite", PCWrite, 0);
    chk("swrst.held_IRWrite", IRWrite, 0);
    rst_n = 1'b1; go = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("swrst.after_state", state_o, 0);

    for (int i = 0; i < 250; i++) begin
      cls_t c;
      c = cls_t'($urandom_range(0, C_NUM - 1));
      run(c, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
